// File: rtl/fir_pkg.sv
// Shared constants, sample/coefficient types and saturation helper for the FIR block.
package fir_pkg;

  localparam int unsigned NUM_TAPS     = 5;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_COEF_W   = 16;
  localparam int unsigned DEF_SCALE    = 10;
  localparam int unsigned ACC_W        = DEF_DATA_W + DEF_COEF_W + $clog2(NUM_TAPS);

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;

  // Clamp a full-width value into the default sample range (no wrap-around).
  function automatic sample_t saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {{(ACC_W-DEF_DATA_W+1){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
    min_v = {{(ACC_W-DEF_DATA_W+1){1'b1}}, {(DEF_DATA_W-1){1'b0}}};
    if (v > max_v)      return max_v[DEF_DATA_W-1:0];
    else if (v < min_v) return min_v[DEF_DATA_W-1:0];
    else                return v[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample stream, coefficient inputs and filtered output of the FIR block.
interface fir_if #(
  parameter int unsigned DATA_W = fir_pkg::DEF_DATA_W,
  parameter int unsigned COEF_W = fir_pkg::DEF_COEF_W
) ();

  logic signed [DATA_W-1:0] input_signal;
  logic signed [COEF_W-1:0] c1;
  logic signed [COEF_W-1:0] c2;
  logic signed [COEF_W-1:0] c3;
  logic signed [COEF_W-1:0] c4;
  logic signed [COEF_W-1:0] c5;
  logic signed [DATA_W-1:0] output_signal;

  modport master (
    output input_signal, c1, c2, c3, c4, c5,
    input  output_signal
  );

  modport slave (
    input  input_signal, c1, c2, c3, c4, c5,
    output output_signal
  );

endinterface

// File: rtl/fir_scale_sat.sv
// Combinational divide-by-SCALE (truncating toward zero) followed by saturation to DATA_W.
module fir_scale_sat #(
  parameter int unsigned DATA_W = fir_pkg::DEF_DATA_W,
  parameter int unsigned ACC_W  = fir_pkg::ACC_W,
  parameter int unsigned SCALE  = fir_pkg::DEF_SCALE
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] y_c
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] quot;

  // A zero divisor is meaningless; stop elaboration rather than build garbage.
  if (SCALE < 1) begin : g_bad_scale
    $error("fir_scale_sat: SCALE must be at least 1");
  end

  // Unity scale needs no divider at all.
  if (SCALE == 1) begin : g_bypass
    assign quot = acc_i;
  end else begin : g_divide
    localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(SCALE);
    // Signed '/' truncates toward zero, which is exactly the rounding we want.
    assign quot = acc_i / DIVISOR;
  end

  // Clamp the quotient into the representable sample range.
  always_comb begin
    y_c = quot[DATA_W-1:0];
    if (quot > MAX_V)      y_c = MAX_V[DATA_W-1:0];
    else if (quot < MIN_V) y_c = MIN_V[DATA_W-1:0];
  end

endmodule

// File: rtl/fir_filter.sv
// 5-tap direct-form FIR: combinational MAC over the delay line, registered scaled/saturated output.
module fir_filter
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned SCALE  = DEF_SCALE
) (
  input  logic clock,
  input  logic reset,
  fir_if.slave bus
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);

  logic signed [DATA_W-1:0] d_q   [NUM_TAPS-1];
  logic signed [DATA_W-1:0] d_d   [NUM_TAPS-1];
  logic signed [DATA_W-1:0] out_q;
  logic signed [DATA_W-1:0] out_d;

  logic signed [DATA_W-1:0] taps  [NUM_TAPS];
  logic signed [COEF_W-1:0] coefs [NUM_TAPS];
  logic signed [PROD_W-1:0] prod  [NUM_TAPS];
  logic signed [SUM_W-1:0]  acc_c;

  // Gather the newest sample with its history, paired with the matching coefficients.
  always_comb begin
    taps[0] = bus.input_signal;
    for (int i = 1; i < int'(NUM_TAPS); i++) taps[i] = d_q[i-1];
    coefs[0] = bus.c1;
    coefs[1] = bus.c2;
    coefs[2] = bus.c3;
    coefs[3] = bus.c4;
    coefs[4] = bus.c5;
  end

  // Full-precision products summed into an accumulator wide enough to never overflow.
  always_comb begin
    acc_c = '0;
    for (int i = 0; i < int'(NUM_TAPS); i++) begin
      prod[i] = PROD_W'(coefs[i]) * PROD_W'(taps[i]);
      acc_c   = acc_c + SUM_W'(prod[i]);
    end
  end

  fir_scale_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (SUM_W),
    .SCALE  (SCALE)
  ) u_scale_sat (
    .acc_i (acc_c),
    .y_c   (out_d)
  );

  // Next delay-line contents: shift by one, newest sample enters at the head.
  always_comb begin
    d_d[0] = bus.input_signal;
    for (int i = 1; i < int'(NUM_TAPS) - 1; i++) d_d[i] = d_q[i-1];
  end

  // Delay line and output register; reset clears history so startup outputs are partial sums.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_TAPS) - 1; i++) d_q[i] <= '0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_TAPS) - 1; i++) d_q[i] <= d_d[i];
      out_q <= out_d;
    end
  end

  assign bus.output_signal = out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed, self-checking bench for fir_filter with hand-computed expected outputs.
module tb_fir_filter;
  import fir_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fir_if bus ();

  fir_filter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic set_coefs(input int a, input int b, input int c, input int d, input int e);
    bus.c1 = DEF_COEF_W'(a);
    bus.c2 = DEF_COEF_W'(b);
    bus.c3 = DEF_COEF_W'(c);
    bus.c4 = DEF_COEF_W'(d);
    bus.c5 = DEF_COEF_W'(e);
  endtask

  // Present one sample, then land 1 time unit after the capturing edge.
  task automatic tick(input int x);
    bus.input_signal = DEF_DATA_W'(x);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.input_signal = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sample_t exp_v;
    set_coefs(2, 2, 2, 2, 2);
    do_reset();
    total++;
    if (bus.output_signal !== sample_t'(0)) begin
      bad++;
      $display("FAIL reset_initial: got %0d expected 0", bus.output_signal);
    end
    tick(10);
    tick(20);
    tick(30);
    exp_v = sample_t'(12);
    total++;
    if (bus.output_signal !== exp_v) begin
      bad++;
      $display("FAIL reset_prefill: got %0d expected %0d", bus.output_signal, exp_v);
    end
    // Assert reset between edges: output must clear without a clock edge.
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (bus.output_signal !== sample_t'(0)) begin
      bad++;
      $display("FAIL reset_async: got %0d expected 0", bus.output_signal);
    end
    tick(50);
    tick(50);
    total++;
    if (bus.output_signal !== sample_t'(0)) begin
      bad++;
      $display("FAIL reset_held: got %0d expected 0", bus.output_signal);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(0);
      total++;
      if (bus.output_signal !== sample_t'(0)) begin
        bad++;
        $display("FAIL reset_zero_in[%0d]: got %0d expected 0", i, bus.output_signal);
      end
    end
  endtask

  task automatic test_boxcar();
    int xs [8];
    int ys [8];
    xs = '{0, 5, 10, 5, 0, -5, -10, -5};
    ys = '{0, 1, 3, 4, 4, 3, 0, -3};
    set_coefs(2, 2, 2, 2, 2);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(xs[i]);
      total++;
      if (bus.output_signal !== DEF_DATA_W'(ys[i])) begin
        bad++;
        $display("FAIL boxcar[%0d]: got %0d expected %0d", i, bus.output_signal, ys[i]);
      end
    end
  endtask

  task automatic test_impulse();
    int ys [6];
    ys = '{1, 2, 3, 4, 5, 0};
    set_coefs(1, 2, 3, 4, 5);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(i == 0 ? 10 : 0);
      total++;
      if (bus.output_signal !== DEF_DATA_W'(ys[i])) begin
        bad++;
        $display("FAIL impulse[%0d]: got %0d expected %0d", i, bus.output_signal, ys[i]);
      end
    end
  endtask

  task automatic test_steady();
    int ys [7];
    ys = '{2, 4, 6, 8, 10, 10, 10};
    set_coefs(2, 2, 2, 2, 2);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(10);
      total++;
      if (bus.output_signal !== DEF_DATA_W'(ys[i])) begin
        bad++;
        $display("FAIL steady[%0d]: got %0d expected %0d", i, bus.output_signal, ys[i]);
      end
    end
  endtask

  task automatic test_truncation();
    int xs [5];
    int ys [5];
    xs = '{-15, 15, -9, 9, -20};
    ys = '{-1, 1, 0, 0, -2};
    set_coefs(1, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(xs[i]);
      total++;
      if (bus.output_signal !== DEF_DATA_W'(ys[i])) begin
        bad++;
        $display("FAIL trunc[%0d]: got %0d expected %0d", i, bus.output_signal, ys[i]);
      end
    end
  endtask

  task automatic test_coef_change();
    // c1 alone, then switch to c2 alone: the very next output uses the new coefficients.
    set_coefs(5, 0, 0, 0, 0);
    do_reset();
    tick(20);
    total++;
    if (bus.output_signal !== sample_t'(10)) begin
      bad++;
      $display("FAIL coef_before: got %0d expected 10", bus.output_signal);
    end
    set_coefs(0, 5, 0, 0, 0);
    tick(0);
    total++;
    if (bus.output_signal !== sample_t'(10)) begin
      bad++;
      $display("FAIL coef_after: got %0d expected 10", bus.output_signal);
    end
  endtask

  task automatic test_saturation();
    set_coefs(32767, 32767, 32767, 32767, 32767);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(32767);
      total++;
      if (bus.output_signal !== sample_t'(32767)) begin
        bad++;
        $display("FAIL sat_pos[%0d]: got %0d expected 32767", i, bus.output_signal);
      end
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(-32768);
      total++;
      if (bus.output_signal !== sample_t'(-32768)) begin
        bad++;
        $display("FAIL sat_neg[%0d]: got %0d expected -32768", i, bus.output_signal);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.input_signal = '0;
    set_coefs(0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_boxcar();
    test_impulse();
    test_steady();
    test_truncation();
    test_coef_change();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
